melody_sequencer: RTL

Score sequencer for the clock's alarm and chime path. On a start pulse it walks an internal score ROM of pitch/duration entries. For each entry it drives a tone half-period and tone-enable for that note's duration, with a short silent gap between notes. Sits directly upstream of the square-wave tone generator, which toggles the beeper every half_period+1 clocks while tone_en is high.

---
 rtl/melody_sequencer.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/melody_sequencer.sv
// Purpose : walks the score ROM and drives tone half-period / enable for the beeper tone generator.
// Latency : start sampled at edge k -> LOAD after k, first pitched note sounds after k+1.
// Backpr. : none; start ignored while busy, stop aborts from any state. Option macro: MELODY_LOOP_EN.
module melody_sequencer #(
  parameter int BEAT_CYCLES = 12500000,
  parameter int GAP_CYCLES  = 1250000,
  parameter int NOTE_COUNT  = 16,
  parameter int REPEAT      = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stop,
  output logic [16:0] half_period,
  output logic        tone_en,
  output logic [3:0]  note_idx,
  output logic        busy,
  output logic        done
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_PLAY = 3'd2;
  localparam logic [2:0] S_GAP  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [25:0] BEAT_LAST = 26'(BEAT_CYCLES - 1);
  localparam logic [25:0] GAP_LAST  = 26'(GAP_CYCLES - 1);
  localparam logic [3:0]  LAST_IDX  = 4'(NOTE_COUNT - 1);

  logic [2:0]  state;
  logic [25:0] clk_cnt;
  logic [2:0]  beat_cnt;
  logic [2:0]  cur_dur;
  logic [6:0]  rom_q;
  logic [3:0]  rom_pitch;
  logic [2:0]  rom_dur;
  logic        eop_take;
  logic        last_pass;

  // Default score: entries 0..13 climb pitch 1..14 for one beat, 14 ends the score.
  function automatic logic [6:0] rom_entry(input logic [3:0] idx);
    logic [6:0] e;
    e = 7'd0;
    if (idx <= 4'd13) e = {idx + 4'd1, 3'd1};
    return e;
  endfunction

  // Pitch code to tone generator compare value; rests and the reserved code give silence.
  function automatic logic [16:0] pitch_hp(input logic [3:0] p);
    logic [16:0] hp;
    case (p)
      4'd1:    hp = 17'd127552;
      4'd2:    hp = 17'd113636;
      4'd3:    hp = 17'd101236;
      4'd4:    hp = 17'd95548;
      4'd5:    hp = 17'd85136;
      4'd6:    hp = 17'd75838;
      4'd7:    hp = 17'd67567;
      4'd8:    hp = 17'd63776;
      4'd9:    hp = 17'd56818;
      4'd10:   hp = 17'd50607;
      4'd11:   hp = 17'd47778;
      4'd12:   hp = 17'd42553;
      4'd13:   hp = 17'd37936;
      4'd14:   hp = 17'd33783;
      default: hp = 17'd0;
    endcase
    return hp;
  endfunction

  assign rom_q     = rom_entry(note_idx);
  assign rom_pitch = rom_q[6:3];
  assign rom_dur   = rom_q[2:0];

  // End of a pass: end marker seen in LOAD, or gap of the last ROM slot finished.
  assign eop_take = !stop &&
                    (((state == S_LOAD) && (rom_dur == 3'd0)) ||
                     ((state == S_GAP) && (clk_cnt == GAP_LAST) && (note_idx == LAST_IDX)));

`ifndef MELODY_LOOP_EN
  logic [7:0] pass_cnt;

  assign last_pass = ((32'(pass_cnt) + 32'd1) >= 32'(REPEAT));

  // Pass counter: cleared when idle or aborted, bumped at each non-final end of pass.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      pass_cnt <= 8'd0;
    else if (stop || state == S_IDLE) pass_cnt <= 8'd0;
    else if (eop_take && !last_pass) pass_cnt <= pass_cnt + 8'd1;
  end
`else
  // Looping build: a pass never counts as the last one, so DONE is unreachable.
  assign last_pass = 1'b0;
`endif

  // Sequencer FSM with registered outputs; stop overrides everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      clk_cnt     <= 26'd0;
      beat_cnt    <= 3'd0;
      cur_dur     <= 3'd0;
      half_period <= 17'd0;
      tone_en     <= 1'b0;
      note_idx    <= 4'd0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      if (stop) begin
        state       <= S_IDLE;
        clk_cnt     <= 26'd0;
        beat_cnt    <= 3'd0;
        half_period <= 17'd0;
        tone_en     <= 1'b0;
        note_idx    <= 4'd0;
        busy        <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              state    <= S_LOAD;
              note_idx <= 4'd0;
              busy     <= 1'b1;
            end
          end
          S_LOAD: begin
            if (eop_take) begin
              if (last_pass) begin
                state <= S_DONE;
                done  <= 1'b1;
              end else begin
                state    <= S_LOAD;
                note_idx <= 4'd0;
              end
            end else begin
              state       <= S_PLAY;
              cur_dur     <= rom_dur;
              half_period <= pitch_hp(rom_pitch);
              tone_en     <= (rom_pitch != 4'd0) && (rom_pitch != 4'hF);
              clk_cnt     <= 26'd0;
              beat_cnt    <= 3'd0;
            end
          end
          S_PLAY: begin
            if (clk_cnt == BEAT_LAST) begin
              clk_cnt <= 26'd0;
              if (beat_cnt == cur_dur - 3'd1) begin
                state       <= S_GAP;
                tone_en     <= 1'b0;
                half_period <= 17'd0;
              end else begin
                beat_cnt <= beat_cnt + 3'd1;
              end
            end else begin
              clk_cnt <= clk_cnt + 26'd1;
            end
          end
          S_GAP: begin
            if (clk_cnt == GAP_LAST) begin
              clk_cnt <= 26'd0;
              if (eop_take) begin
                if (last_pass) begin
                  state <= S_DONE;
                  done  <= 1'b1;
                end else begin
                  state    <= S_LOAD;
                  note_idx <= 4'd0;
                end
              end else begin
                state    <= S_LOAD;
                note_idx <= note_idx + 4'd1;
              end
            end else begin
              clk_cnt <= clk_cnt + 26'd1;
            end
          end
          S_DONE: begin
            state    <= S_IDLE;
            busy     <= 1'b0;
            note_idx <= 4'd0;
          end
          default: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
